// File: rtl/dreimann_game_top.sv
// -----------------------------------------------------------------------------
// dreimann_game_top
//   Game engine for the "Drei Mann" dice game in the tiny-tapeout wrapper shape.
//   Each rising edge of the roll button (while enabled) produces two dice,
//   taken from a free-running LFSR or from test inputs. The roll is then
//   classified, and the block tracks the current player and the Dreimann
//   holder for 2-4 players.
//
// Ports:
//   clk      in   system clock, all state on the rising edge
//   rst      in   synchronous active-high reset
//   ena      in   enable; roll requests are ignored while low (LFSR keeps running)
//   ui_in    in   [0] roll button, [1] test mode, [4:2] test die1, [7:5] test die2
//   uo_out   out  [2:0] die1, [5:3] die2, [7:6] event code
//   uio_in   in   [1:0] player-count code (0->2, 1->3, 2/3->4); [7:2] ignored
//   uio_out  out  [1:0] 0, [2] dm_drinks, [4:3] current player,
//                 [6:5] Dreimann holder, [7] holder_valid
//   uio_oe   out  constant 8'hFC (upper six bidirectional pins are outputs)
// -----------------------------------------------------------------------------
module dreimann_game_top #(
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef enum logic [1:0] {
    EV_NONE   = 2'b00,
    EV_LEFT   = 2'b01,
    EV_RIGHT  = 2'b10,
    EV_DOUBLE = 2'b11
  } event_e;

  // Map a random nibble (0..15) onto a die face 1..6.
  function automatic logic [2:0] nib_to_die(input logic [3:0] nib);
    logic [3:0] rem;
    rem = nib % 4'd6;
    return rem[2:0] + 3'd1;
  endfunction

  // Test dice are 3-bit raw values; 0 and 7 are not faces, so pull them in.
  function automatic logic [2:0] clamp_die(input logic [2:0] raw);
    logic [2:0] res;
    case (raw)
      3'd0:    res = 3'd1;
      3'd7:    res = 3'd6;
      default: res = raw;
    endcase
    return res;
  endfunction

  // Player-count code to number of players.
  function automatic logic [2:0] players_from_code(input logic [1:0] code);
    logic [2:0] res;
    case (code)
      2'd0:    res = 3'd2;
      2'd1:    res = 3'd3;
      default: res = 3'd4;
    endcase
    return res;
  endfunction

  // State registers
  logic [15:0] lfsr_q,         lfsr_d;
  logic        roll_prev_q,    roll_prev_d;
  logic [2:0]  die1_q,         die1_d;
  logic [2:0]  die2_q,         die2_d;
  event_e      event_q,        event_d;
  logic        dm_drinks_q,    dm_drinks_d;
  logic [1:0]  cur_q,          cur_d;
  logic [1:0]  holder_q,       holder_d;
  logic        holder_valid_q, holder_valid_d;

  // Combinational helpers
  logic        roll_s;
  logic [2:0]  die1_s;
  logic [2:0]  die2_s;
  logic [3:0]  sum_s;
  event_e      event_s;
  logic        has_three_s;
  logic [2:0]  n_players_s;
  logic [2:0]  cur_inc_s;
  logic        unused_s;

  assign unused_s = ^uio_in[7:2];

  // LFSR step, roll edge detection and dice selection.
  always_comb begin
    // x^16 + x^14 + x^13 + x^11 + 1, shifting toward the MSB
    lfsr_d      = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    roll_prev_d = ui_in[0];
    roll_s      = ui_in[0] & ~roll_prev_q & ena;

    if (ui_in[1]) begin
      die1_s = clamp_die(ui_in[4:2]);
      die2_s = clamp_die(ui_in[7:5]);
    end else begin
      die1_s = nib_to_die(lfsr_q[3:0]);
      die2_s = nib_to_die(lfsr_q[7:4]);
    end
  end

  // Roll classification and next-player computation.
  always_comb begin
    sum_s       = {1'b0, die1_s} + {1'b0, die2_s};
    has_three_s = (die1_s == 3'd3) || (die2_s == 3'd3);
    n_players_s = players_from_code(uio_in[1:0]);
    cur_inc_s   = {1'b0, cur_q} + 3'd1;

    // Sums 7 and 11 are odd, so they can never coincide with doubles.
    if (sum_s == 4'd7) begin
      event_s = EV_LEFT;
    end else if (sum_s == 4'd11) begin
      event_s = EV_RIGHT;
    end else if (die1_s == die2_s) begin
      event_s = EV_DOUBLE;
    end else begin
      event_s = EV_NONE;
    end
  end

  // Next-state for the result registers; everything holds unless a roll lands.
  always_comb begin
    die1_d         = die1_q;
    die2_d         = die2_q;
    event_d        = event_q;
    dm_drinks_d    = dm_drinks_q;
    cur_d          = cur_q;
    holder_d       = holder_q;
    holder_valid_d = holder_valid_q;

    if (roll_s) begin
      die1_d      = die1_s;
      die2_d      = die2_s;
      event_d     = event_s;
      // Uses the holder status from before this roll.
      dm_drinks_d = has_three_s && holder_valid_q;

      if (sum_s == 4'd3) begin
        holder_d       = cur_q;
        holder_valid_d = 1'b1;
      end else begin
        holder_d       = holder_q;
        holder_valid_d = holder_valid_q;
      end

      // Turn passes only on a plain roll; an out-of-range player also wraps to 0.
      if ((event_s == EV_NONE) && !has_three_s && (sum_s != 4'd3)) begin
        if (cur_inc_s >= n_players_s) begin
          cur_d = 2'd0;
        end else begin
          cur_d = cur_inc_s[1:0];
        end
      end else begin
        cur_d = cur_q;
      end
    end else begin
      cur_d = cur_q;
    end
  end

  // All state registers; reset takes priority over a simultaneous roll.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q         <= LFSR_SEED;
      roll_prev_q    <= 1'b0;
      die1_q         <= 3'd0;
      die2_q         <= 3'd0;
      event_q        <= EV_NONE;
      dm_drinks_q    <= 1'b0;
      cur_q          <= 2'd0;
      holder_q       <= 2'd0;
      holder_valid_q <= 1'b0;
    end else begin
      lfsr_q         <= lfsr_d;
      roll_prev_q    <= roll_prev_d;
      die1_q         <= die1_d;
      die2_q         <= die2_d;
      event_q        <= event_d;
      dm_drinks_q    <= dm_drinks_d;
      cur_q          <= cur_d;
      holder_q       <= holder_d;
      holder_valid_q <= holder_valid_d;
    end
  end

  assign uo_out  = {event_q, die2_q, die1_q};
  assign uio_out = {holder_valid_q, holder_q, cur_q, dm_drinks_q, 2'b00};
  assign uio_oe  = 8'hFC;

endmodule

// File: tb/tb_dreimann_game_top.sv
// -----------------------------------------------------------------------------
// tb_dreimann_game_top
//   Directed and randomized checks of dreimann_game_top against a game-rule
//   reference model (integer player/holder state, dice from the LFSR sequence).
// -----------------------------------------------------------------------------
module tb_dreimann_game_top;

  logic       clk;
  logic       rst;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int tests = 0;
  int fails = 0;

  // Reference model state
  logic [15:0] m_lfsr;
  int          m_d1, m_d2, m_ev, m_dm, m_cur, m_holder, m_hv;

  dreimann_game_top #(.LFSR_SEED(16'hACE1)) dut (
    .clk     (clk),
    .rst     (rst),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference pseudo-random sequence: polynomial x^16+x^14+x^13+x^11+1, one step per clock.
  always @(posedge clk) begin
    if (rst) m_lfsr <= 16'hACE1;
    else     m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  task automatic model_reset();
    m_d1 = 0; m_d2 = 0; m_ev = 0; m_dm = 0;
    m_cur = 0; m_holder = 0; m_hv = 0;
  endtask

  // Apply the game rules to one roll.
  task automatic model_roll(input int d1, input int d2, input int n);
    int sum;
    bit three;
    sum   = d1 + d2;
    three = (d1 == 3) || (d2 == 3);
    m_d1  = d1;
    m_d2  = d2;
    if (sum == 7)       m_ev = 1;
    else if (sum == 11) m_ev = 2;
    else if (d1 == d2)  m_ev = 3;
    else                m_ev = 0;
    m_dm = (three && m_hv != 0) ? 1 : 0;
    if (m_ev == 0 && !three && sum != 3)
      m_cur = (m_cur + 1 >= n) ? 0 : m_cur + 1;
    else if (sum == 3) begin
      m_holder = m_cur;
      m_hv     = 1;
    end
  endtask

  function automatic logic [7:0] exp_uo();
    return 8'((m_ev << 6) | (m_d2 << 3) | m_d1);
  endfunction

  function automatic logic [7:0] exp_uio();
    return 8'((m_hv << 7) | (m_holder << 5) | (m_cur << 3) | (m_dm << 2));
  endfunction

  function automatic int clamp(input int raw);
    if (raw == 0) return 1;
    if (raw == 7) return 6;
    return raw;
  endfunction

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check8({tag, "_uo"},  uo_out,  exp_uo());
    check8({tag, "_uio"}, uio_out, exp_uio());
    check8({tag, "_oe"},  uio_oe,  8'hFC);
  endtask

  // One button press (high for one edge, then low for one edge).
  task automatic roll(input bit test, input int r1, input int r2,
                      input int ncode, input bit en, input string tag);
    int d1, d2;
    @(negedge clk);
    ena    = en;
    uio_in = {6'($urandom), 2'(ncode)};
    ui_in  = {3'(r2), 3'(r1), test, 1'b1};
    if (test) begin
      d1 = clamp(r1);
      d2 = clamp(r2);
    end else begin
      d1 = int'(m_lfsr[3:0]) % 6 + 1;
      d2 = int'(m_lfsr[7:4]) % 6 + 1;
    end
    if (en) model_roll(d1, d2, (ncode == 0) ? 2 : (ncode == 1) ? 3 : 4);
    @(posedge clk);
    #1;
    check_all(tag);
    @(negedge clk);
    ui_in[0] = 1'b0;
  endtask

  initial begin
    int  first_die;
    bit  range_ok;
    bit  varied;

    rst    = 1'b1;
    ena    = 1'b1;
    ui_in  = 8'd0;
    uio_in = 8'd1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;

    // Directed sequence, N=3
    roll(1'b1, 1, 2, 1, 1'b1, "r12_new_dm");
    roll(1'b1, 3, 5, 1, 1'b1, "r35_dm_drinks");
    roll(1'b1, 2, 4, 1, 1'b1, "r24_pass");
    roll(1'b1, 3, 4, 1, 1'b1, "r34_seven");
    roll(1'b1, 5, 6, 1, 1'b1, "r56_eleven");
    roll(1'b1, 4, 4, 1, 1'b1, "r44_double");
    roll(1'b1, 1, 5, 1, 1'b1, "r15_to2");
    roll(1'b1, 1, 5, 1, 1'b1, "r15_wrap");
    roll(1'b1, 0, 7, 1, 1'b1, "clamp_07");
    roll(1'b1, 7, 0, 0, 1'b1, "clamp_70");

    // Player shrinks below current player: N=4 go to cur 3, then N=2 wraps to 0
    roll(1'b1, 1, 5, 3, 1'b1, "n4_a");
    roll(1'b1, 1, 5, 3, 1'b1, "n4_b");
    roll(1'b1, 1, 5, 3, 1'b1, "n4_c");
    roll(1'b1, 1, 5, 0, 1'b1, "n2_oor");

    // Disabled roll leaves everything alone
    roll(1'b1, 6, 6, 1, 1'b0, "ena0");
    roll(1'b0, 0, 0, 1, 1'b0, "ena0_rand");
    ena = 1'b1;

    // Held button: one roll, then nothing for nine more edges
    roll(1'b1, 1, 5, 1, 1'b1, "hold_first");
    @(negedge clk);
    ui_in = {3'd5, 3'd1, 1'b1, 1'b1};
    // The line above re-raises the button once more as a real press
    model_roll(1, 5, 3);
    repeat (10) begin
      @(posedge clk);
      #1;
      check_all("hold");
    end
    @(negedge clk);
    ui_in[0] = 1'b0;

    // Random mode
    range_ok  = 1'b1;
    varied    = 1'b0;
    first_die = -1;
    for (int i = 0; i < 100; i++) begin
      roll(1'b0, 0, 0, int'($urandom_range(0, 3)), 1'b1, "rand");
      if (m_d1 < 1 || m_d1 > 6 || m_d2 < 1 || m_d2 > 6) range_ok = 1'b0;
      if (int'(uo_out[2:0]) < 1 || int'(uo_out[2:0]) > 6) range_ok = 1'b0;
      if (int'(uo_out[5:3]) < 1 || int'(uo_out[5:3]) > 6) range_ok = 1'b0;
      if (first_die < 0) first_die = int'(uo_out[5:0]);
      else if (int'(uo_out[5:0]) != first_die) varied = 1'b1;
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end
    check8("rand_range",  {7'd0, range_ok}, 8'd1);
    check8("rand_varied", {7'd0, varied},   8'd1);

    // Reset during play, coinciding with a button press
    @(negedge clk);
    rst   = 1'b1;
    ui_in = {3'd1, 3'd2, 1'b1, 1'b1};
    model_reset();
    @(posedge clk);
    #1;
    check_all("mid_reset");
    @(negedge clk);
    rst   = 1'b0;
    ui_in = 8'd0;

    // LFSR restarted from the seed
    roll(1'b0, 0, 0, 2, 1'b1, "post_reset_rand");
    roll(1'b0, 0, 0, 2, 1'b1, "post_reset_rand2");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dreimann_game_top.md
Name: dreimann_game_top

Overview:
- Top-level game engine for the "Drei Mann" dice drinking game, in the standard tiny-tapeout user-project wrapper shape.
- Each roll request produces two dice values, from a free-running LFSR or from test inputs.
- Each roll is classified (7 / 11 / doubles / three), and the block tracks the current player and the Dreimann holder for 2–4 players.
- All state lives in this block; no submodules are required beyond an optional LFSR helper.

Parameters:
- LFSR_SEED, 16'hACE1, LFSR value loaded on reset.

Ports:
- clk  in  1  system clock; all registers on rising edge.
- rst  in  1  synchronous, active-high reset.
- ena  in  1  design enable; when 0, roll requests are ignored (LFSR still runs).
- ui_in  in  8  [0] roll button; [1] test mode; [4:2] test die1; [7:5] test die2.
- uo_out  out  8  [2:0] die1; [5:3] die2; [7:6] event code.
- uio_in  in  8  [1:0] player-count code (0→2, 1→3, 2→4, 3→4 players); [7:2] ignored.
- uio_out  out  8  [1:0] always 0; [2] dm_drinks; [4:3] current player; [6:5] Dreimann holder; [7] holder_valid.
- uio_oe  out  8  constant 8'hFC.

Behaviour:
- LFSR: 16-bit Fibonacci, taps x^16+x^14+x^13+x^11+1, shifts every clock including ena=0. Reset loads LFSR_SEED.
- Roll detect: register roll_prev <= ui_in[0] every cycle. roll = ui_in[0] & ~roll_prev & ena. No synchronizer.
- Latency: on the clock edge where roll=1, all result registers load. Outputs are visible immediately after that edge and hold until the next roll or reset.
- Random dice (ui_in[1]=0): die1 = (lfsr[3:0] mod 6)+1; die2 = (lfsr[7:4] mod 6)+1.
- Test dice (ui_in[1]=1): die1 = ui_in[4:2], die2 = ui_in[7:5]. Clamp 0→1 and 7→6.
- sum = die1+die2, 4 bits, range 2..12.
- Event code, mutually exclusive:
  - 01 if sum==7 (left drinks).
  - 10 if sum==11 (right drinks).
  - 11 if die1==die2 (doubles).
  - else 00.
- New Dreimann: if sum==3, holder <= current player and holder_valid <= 1, evaluated on the same edge.
- dm_drinks = (die1==3 || die2==3) && holder_valid. Use the holder_valid value before this roll's update.
- Turn pass: if event==00 && die1!=3 && die2!=3 && sum!=3, then current player <= (cur+1 >= N) ? 0 : cur+1. Otherwise the current player keeps the turn.
- N is sampled from uio_in[1:0] at each roll. If cur >= N at roll time, the next player is 0.
- Reset values:
  - dice 0 (0 means "no roll yet"); event 00; dm_drinks 0.
  - current player 0; holder 0; holder_valid 0; roll_prev 0.
  - uio_out[1:0] 0; uio_oe 8'hFC.
- Reset mid-operation: reset wins over a simultaneous roll. All state returns to reset values on that edge.
- Holding ui_in[0] high produces exactly one roll. A new roll requires a low cycle first.

Test Plan:
- Reset, ena=1, uio_in=1 (N=3), test mode, roll (1,2) → uo_out die1=1/die2=2, event 00, holder=0, holder_valid=1, cur=0, dm_drinks=0.
- Then roll (3,5) → dm_drinks=1, event 00, cur stays 0. Then roll (2,4) → event 00, cur=1.
- Roll (3,4) → event 01, cur unchanged. Roll (5,6) → event 10. Roll (4,4) → event 11, cur unchanged.
- Wrap: N=3, cur=1, rolls (1,5) twice → cur=2 then 0. Test die inputs 0 and 7 → shown as 1 and 6.
- Random mode: 100 rolls, ui_in[0] held ≥1 cycle each with low gaps → every die in 1..6, values not constant. ena=0 rolls → outputs unchanged. Holding button high 10 cycles → only one update.
- Assert rst during play → next cycle: uo_out=0, uio_out=0, uio_oe=FC, holder_valid=0.
